// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider (2N/N -> 2N quotient, N remainder); DIV_ZERO_DETECT_EN short-circuits divide-by-zero
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           dz_flag
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(2 * N);
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] shf_q, shf_d, quotient_q, quotient_d;
    logic [N:0]     rem_q, rem_d, rem_sh, rem_sub, rem_nxt;
    logic [N-1:0]   dsr_q, dsr_d, remainder_q, remainder_d;
    logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, take;
`ifdef DIV_ZERO_DETECT_EN
    logic           dz_q, dz_d;
    assign dz_flag = dz_q;
`else
    assign dz_flag = 1'b0;
`endif
    assign rem_sh    = {rem_q[N-1:0], shf_q[2*N-1]};
    assign rem_sub   = rem_sh - {1'b0, dsr_q};
    assign take      = rem_sh >= {1'b0, dsr_q};
    assign rem_nxt   = take ? rem_sub : rem_sh;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    // next-state: accept in IDLE, one quotient bit per RUN cycle (dividend shifts out as quotient shifts in), hold in DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shf_d       = shf_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d        = dz_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                shf_d      = dividend;
                dsr_d      = divisor;
                rem_d      = '0;
                cnt_d      = CW'(2 * N - 1);
                state_d    = RUN;
                in_ready_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                if (divisor == '0) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = dividend[N-1:0];
                    out_valid_d = 1'b1;
                    dz_d        = 1'b1;
                end
`endif
            end
            RUN: begin
                shf_d = {shf_q[2*N-2:0], take};
                rem_d = rem_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    quotient_d  = {shf_q[2*N-2:0], take};
                    remainder_d = rem_nxt[N-1:0];
                end
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                dz_d        = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers with synchronous reset that discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shf_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shf_q       <= shf_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q        <= dz_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of the divider against integer division
module tb_seq_restoring_divider;
    localparam int N = 4;
    localparam int W = 2 * N;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         in_ready, out_valid, dz_flag;
    logic [W-1:0] quotient;
    logic [N-1:0] remainder;
    int compared = 0;
    int mismatched = 0;

    seq_restoring_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .dz_flag(dz_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [N-1:0] b, input int stall, input bit inject);
        logic [W-1:0] eq;
        logic [N-1:0] er;
        int lat, c;
        if (b == 0) begin
            eq = '1;
            er = a[N-1:0];
        end else begin
            eq = a / W'(b);
            er = N'(a % W'(b));
        end
        lat = (b == 0 && DZ) ? 0 : W;
        c = 0;
        while (!in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor = N'($urandom);
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 100) begin
            chk("in_ready_busy", in_ready, 0);
            out_ready = 1'($urandom);
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        chk("latency", c, lat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("dz_flag", dz_flag, (b == 0 && DZ) ? 1 : 0);
        out_ready = 1'b0;
        if (inject) begin
            in_valid = 1'b1;
            dividend = 50;
            divisor = 5;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_quotient", quotient, eq);
            chk("stall_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'($urandom);
        @(negedge clk);
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("post_dz", dz_flag, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", dz_flag, 0);
        op(200, 7, 0, 0);
        op(255, 15, 0, 0);
        op(5, 9, 0, 0);
        op(0, 3, 0, 0);
        op(13, 0, 0, 0);
        op(100, 6, 5, 1);
        op(50, 5, 0, 0);
        in_valid = 1'b1;
        dividend = 200;
        divisor = 7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        op(77, 3, 0, 0);
        for (int k = 0; k < 500; k++)
            op(W'($urandom), N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse datapath of the array multiplier tile: a 2N-bit dividend and an N-bit divisor produce a 2N-bit quotient and an N-bit remainder.
- Sits behind the tile's input/output pin mux. Operands are captured through a valid/ready input handshake; results are presented through a valid/ready output handshake.
- Computes one quotient bit per clock.

Parameters:
- N, 4, divisor/remainder width; dividend/quotient width is 2N. Legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- dividend  input  2N  unsigned dividend, sampled on input handshake.
- divisor  input  N  unsigned divisor, sampled on input handshake.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  2N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- dz_flag  output  1  divide-by-zero indicator (see Optional Feature).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient=0, remainder=0, dz_flag=0; iteration counter=0.
  - Reset overrides everything, including mid-RUN and DONE; any in-flight result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: latch dividend into the shift register, divisor into the divisor register, and clear the (N+1)-bit partial remainder R. Counter=2N-1, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: R' = {R[N-1:0], dividend_msb}; dividend shifts left.
  - If R' >= {1'b0, divisor}: R = R' - divisor and shift quotient bit 1 in; else R = R' and shift 0 in.
  - When counter==0, load outputs and go to DONE; otherwise decrement the counter.
- DONE:
  - out_valid=1; quotient/remainder held stable.
  - On out_ready=1, go to IDLE.
  - in_ready=0 throughout; no overlap of input and output handshakes.
- Latency:
  - Input handshake at edge E0 → 2N iteration edges (E1..E2N).
  - out_valid is high in the cycle following E2N, i.e. 2N cycles after acceptance.
  - Minimum throughput is one operation per 2N+2 cycles with out_ready held high.
- Output registers change only on entry to DONE or on reset. While out_valid=1 they must not change regardless of in_valid.
- in_valid asserted during RUN/DONE is ignored; not queued.
- out_ready outside DONE is ignored.
- Width rules:
  - R is N+1 bits; the subtraction is N+1 bits unsigned.
  - remainder = R[N-1:0], always < divisor when divisor≠0.
- Divisor==0 result, mandatory in both builds:
  - quotient = all ones (2^(2N)-1).
  - remainder = dividend[N-1:0].
  - This falls out of the restoring iteration naturally.
- Dividend==0: quotient=0, remainder=0, full latency.

Optional Feature:
- Macro DIV_ZERO_DETECT_EN.
- Defined:
  - Divisor==0 is detected at the input handshake; RUN is skipped.
  - Go IDLE→DONE directly, with quotient = all ones and remainder = dividend[N-1:0].
  - out_valid is high the cycle after acceptance.
  - dz_flag=1 alongside out_valid for that result; dz_flag is cleared when leaving DONE.
- Not defined:
  - Divisor==0 takes the full 2N-cycle path with identical quotient/remainder values.
  - dz_flag is tied 0.
- Nonzero-divisor behaviour and timing are identical in both builds.

Test Plan (N=4):
- 200/7, out_ready=1 → out_valid exactly 8 cycles after accept; quotient=28, remainder=4; in_ready high again the cycle after the output handshake.
- 255/15 → quotient=17, remainder=0; 5/9 → quotient=0, remainder=5; 0/3 → quotient=0, remainder=0.
- 13/0 → quotient=255, remainder=13.
  - With DIV_ZERO_DETECT_EN: out_valid 1 cycle after accept, dz_flag=1.
  - Without: 8 cycles, dz_flag=0.
- Backpressure: 100/6 with out_ready=0 for 5 cycles → out_valid, quotient=16 and remainder=4 held stable. A new in_valid=1 with 50/5 during this window is ignored (in_ready=0). Release out_ready → IDLE, then 50/5 → quotient=10, remainder=0.
- Reset mid-operation: start 200/7, assert rst on the 3rd RUN cycle → next cycle in_ready=1, out_valid=0, quotient=0, remainder=0. Then 77/3 → quotient=25, remainder=2 with normal latency.
- Random sweep: 500 random dividend/divisor pairs with random out_ready stalls → all match an integer reference model and the latency rule.
